fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Fetch-side next-PC generator. It sits directly downstream of the branch decision stage and consumes its 2-bit pc_sel.
- Holds the architectural fetch PC and issues instruction-fetch requests over a valid/ready handshake.
- Selects among sequential (PC+4), PC-relative (branch/jal) and register-relative (jalr) targets.
- Buffers a redirect that arrives while a fetch request is back-pressured, and pulses a flush for wrong-path instructions.

Parameters:
- XLEN, 64, width of PC, immediate and rs1 operands.
- RESET_PC, 64'h0000_0000_0000_0000, PC fetched first after reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_sel  input  2  {b_jal, jalr} from branch decision; 00 sequential, 10 PC+imm, 01 jalr, 11 treated as 10.
- ex_valid  input  1  qualifies pc_sel/ex_* this cycle.
- ex_pc  input  XLEN  PC of the resolving branch/jump.
- ex_imm  input  XLEN  sign-extended immediate.
- ex_rs1  input  XLEN  rs1 value for jalr.
- stall_i  input  1  inhibits raising a new fetch request.
- if_req_valid  output  1  fetch request valid.
- if_req_ready  input  1  instruction memory accepts request.
- if_req_pc  output  XLEN  fetch address; equals pc register.
- flush_o  output  1  one-cycle pulse: discard fetched-but-unretired wrong-path instructions.
- misalign_o  output  1  misaligned-target pulse (see Optional Feature).

Behaviour:
- Redirect: redirect = ex_valid & (pc_sel != 00).
- Target for pc_sel 10/11: ex_pc + ex_imm.
- Target for pc_sel 01: (ex_rs1 + ex_imm) with bit0 cleared.
- All arithmetic is modulo 2^XLEN (wrap, no overflow flag). Sequential next = pc + 4, also wrapping.
- Reset (async, any time including mid-request): state=BOOT, pc=RESET_PC, pend_valid=0, pend_pc=0, if_req_valid=0, flush_o=0, misalign_o=0.
- States:
  - BOOT: entered only via reset; leaves after one cycle. Goes to REQ if ~stall_i, else IDLE.
  - IDLE: if_req_valid=0. A redirect loads pc<=target directly. Goes to REQ when ~stall_i.
  - REQ: if_req_valid=1. if_req_pc is held stable until the handshake (valid & ready) completes.
- Handshake completes in REQ, priority order for the new pc:
  1. Redirect this cycle: pc<=target.
  2. Else pend_valid: pc<=pend_pc, pend_valid<=0.
  3. Else: pc<=pc+4.
  - Then next state is REQ if ~stall_i, else IDLE.
- Redirect in REQ with if_req_ready=0: pend_pc<=target, pend_valid<=1. pc and if_req_pc are unchanged (handshake stability). A later redirect overwrites pend_pc (newest wins).
- pend_valid set on entry to IDLE: pc<=pend_pc in that same edge, pend_valid<=0. No pending redirect survives in IDLE.
- stall_i never drops an asserted if_req_valid. It only prevents re-assertion after acceptance.
- flush_o: registered. Asserts exactly the cycle after any redirect, one cycle wide. Back-to-back redirects give consecutive pulses.
- Latency: redirect in cycle N with ready (or in IDLE) gives if_req_pc=target in cycle N+1.
- A request accepted in cycle N together with a redirect carries the old (wrong-path) PC and is covered by flush_o at N+1.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined: any redirect whose target has bit1 set (target[1:0] != 0 after the jalr bit0 clear) asserts misalign_o for exactly the cycle after the redirect, aligned with flush_o. The redirect is still taken unchanged; trap handling is downstream.
- Undefined: misalign_o is tied 0 and no check logic is generated.

Test Plan:
- Reset then idle memory (ready=1, stall=0) -> if_req_valid=0 in BOOT cycle, then if_req_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles; flush_o=0.
- ex_valid=1, pc_sel=10, ex_pc=0x100, ex_imm=-8 with ready=1 -> next cycle if_req_pc=0xF8, flush_o=1 for one cycle, then 0xFC.
- pc_sel=01, ex_rs1=0x2001, ex_imm=0x10, ready=1 -> if_req_pc=0x2010 (bit0 cleared). With FETCH_MISALIGN_CHK_EN, ex_rs1=0x2003 -> if_req_pc=0x2012 and misalign_o=1 for one cycle.
- Request 0x40 outstanding with ready=0, two redirects (targets 0x800 then 0x900) -> if_req_pc stays 0x40 until ready. After acceptance if_req_pc=0x900; flush_o pulses twice.
- stall_i=1 while request pending with ready=0 -> if_req_valid stays 1 until accepted, then 0. Deassert stall -> request resumes at pc+4.
- rst_n low mid-REQ with pend_valid=1 -> outputs return to reset values immediately. After release, fetch restarts at RESET_PC with no pending target applied.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module   : fetch_pc_gen
// Purpose  : Fetch-side next-PC generator with valid/ready fetch requests,
//            redirect buffering under back-pressure and wrong-path flush.
// Options  : FETCH_MISALIGN_CHK_EN enables the misaligned-target pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            stall_i,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_pc,
  output logic            flush_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_IDLE = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_pend_valid;
  logic            w_pend_valid_nxt;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            r_flush;

  logic            w_redirect;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_seq;

  assign w_redirect  = ex_valid & (pc_sel != 2'b00);
  assign w_br_target = ex_pc + ex_imm;
  assign w_jalr_sum  = ex_rs1 + ex_imm;
  // pc_sel 11 behaves like 10, so only the pure jalr encoding selects rs1.
  assign w_target    = (pc_sel == 2'b01) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;
  assign w_pc_seq    = r_pc + {{(XLEN-3){1'b0}}, 3'd4};

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    case (r_state)
      S_BOOT, S_IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (r_pend_valid) begin
          w_pc_nxt = r_pend_pc;
        end
        w_pend_valid_nxt = 1'b0;
        w_state_nxt      = stall_i ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        if (if_req_ready) begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end else if (r_pend_valid) begin
            w_pc_nxt = r_pend_pc;
          end else begin
            w_pc_nxt = w_pc_seq;
          end
          w_pend_valid_nxt = 1'b0;
          w_state_nxt      = stall_i ? S_IDLE : S_REQ;
        end else if (w_redirect) begin
          // Request address must stay stable; newest redirect wins the buffer.
          w_pend_pc_nxt    = w_target;
          w_pend_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= {XLEN{1'b0}};
      r_flush      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_flush      <= w_redirect;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redirect & (|w_target[1:0]);
    end
  end

  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

  assign if_req_valid = (r_state == S_REQ);
  assign if_req_pc    = r_pc;
  assign flush_o      = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
// Module   : tb_fetch_pc_gen
// Purpose  : Self-checking bench for fetch_pc_gen: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic [63:0] ex_rs1;
  logic        stall_i;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_pc;
  logic        flush_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding-request flag, fetch address, queue of
  // redirects received while back-pressured, and the expected pulses.
  bit          m_req;
  logic [63:0] m_pc;
  logic [63:0] m_pend[$];
  bit          m_flush;
  bit          m_mis;

  fetch_pc_gen #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_sel       (pc_sel),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .stall_i      (stall_i),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_pc    (if_req_pc),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_req   = 1'b0;
    m_pc    = 64'h0;
    m_pend.delete();
    m_flush = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    bit          redir;
    redir = ex_valid && (pc_sel != 2'b00);
    if (pc_sel == 2'b01) tgt = (ex_rs1 + ex_imm) & ~64'd1;
    else                 tgt = ex_pc + ex_imm;
    m_flush = redir;
    m_mis   = MIS_EN && redir && (tgt % 4 != 0);
    if (!m_req) begin
      if (redir) m_pc = tgt;
      else if (m_pend.size() != 0) m_pc = m_pend[$];
      m_pend.delete();
      m_req = !stall_i;
    end else if (if_req_ready) begin
      if (redir)                   m_pc = tgt;
      else if (m_pend.size() != 0) m_pc = m_pend[$];
      else                         m_pc = m_pc + 64'd4;
      m_pend.delete();
      m_req = !stall_i;
    end else if (redir) begin
      m_pend.push_back(tgt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; pc_sel = 2'b00; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    stall_i = 1'b0; if_req_ready = 1'b1; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (if_req_valid !== 1'b0 || if_req_pc !== 64'h0 || flush_o !== 1'b0 || misalign_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b pc=%h flush=%b mis=%b, want 0/0/0/0", if_req_valid, if_req_pc, flush_o, misalign_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (if_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL boot_valid: valid=%b, want 0", if_req_valid);
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_req_valid !== 1'b1 || if_req_pc !== 64'(4 * i) || flush_o !== 1'b0) begin
        n_err++;
        $display("FAIL seq_fetch[%0d]: valid=%b pc=%h flush=%b, want 1/%h/0", i, if_req_valid, if_req_pc, flush_o, 64'(4 * i));
      end
      cycle();
    end
  endtask

  task automatic test_branch();
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h100; ex_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'hF8 || flush_o !== 1'b1 || if_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL branch_target: pc=%h flush=%b valid=%b, want 00f8/1/1", if_req_pc, flush_o, if_req_valid);
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'hFC || flush_o !== 1'b0) begin
      n_err++;
      $display("FAIL branch_next: pc=%h flush=%b, want 00fc/0", if_req_pc, flush_o);
    end
    cycle();
  endtask

  task automatic test_jalr();
    ex_valid = 1'b1; pc_sel = 2'b01; ex_rs1 = 64'h2001; ex_imm = 64'h10; ex_pc = 64'h5555;
    cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'h2010 || flush_o !== 1'b1 || misalign_o !== 1'b0) begin
      n_err++;
      $display("FAIL jalr_target: pc=%h flush=%b mis=%b, want 2010/1/0", if_req_pc, flush_o, misalign_o);
    end
    ex_valid = 1'b1; pc_sel = 2'b01; ex_rs1 = 64'h2003; ex_imm = 64'h10;
    cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'h2012 || flush_o !== 1'b1 || misalign_o !== MIS_EN) begin
      n_err++;
      $display("FAIL jalr_misalign: pc=%h flush=%b mis=%b, want 2012/1/%b", if_req_pc, flush_o, misalign_o, MIS_EN);
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (misalign_o !== 1'b0 || flush_o !== 1'b0 || if_req_pc !== 64'h2016) begin
      n_err++;
      $display("FAIL jalr_after: pc=%h flush=%b mis=%b, want 2016/0/0", if_req_pc, flush_o, misalign_o);
    end
    cycle();
  endtask

  task automatic test_wrap();
    ex_valid = 1'b1; pc_sel = 2'b11; ex_pc = 64'hFFFF_FFFF_FFFF_FFF8; ex_imm = 64'h4;
    cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_target: pc=%h, want fffffffffffffffc", if_req_pc);
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'h0) begin
      n_err++;
      $display("FAIL wrap_seq: pc=%h, want 0", if_req_pc);
    end
    cycle();
  endtask

  task automatic test_backpressure_redirect();
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h40; ex_imm = 64'h0;
    cycle();
    if_req_ready = 1'b0; ex_pc = 64'h800;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_req_pc !== 64'h40 || if_req_valid !== 1'b1 || flush_o !== (i < 3)) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: pc=%h valid=%b flush=%b, want 0040/1/%b", i, if_req_pc, if_req_valid, flush_o, (i < 3));
      end
      cycle();
      if (i == 0) ex_pc = 64'h900;
      else if (i == 1) idle_inputs();
      else if (i == 2) if_req_ready = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (if_req_pc !== 64'h900 || if_req_valid !== 1'b1 || flush_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_newest: pc=%h valid=%b flush=%b, want 0900/1/0", if_req_pc, if_req_valid, flush_o);
    end
    cycle();
  endtask

  task automatic test_stall();
    logic [63:0] p0;
    p0 = m_pc;
    if_req_ready = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_req_valid !== 1'b1 || if_req_pc !== p0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h, want 1/%h", i, if_req_valid, if_req_pc, p0);
      end
      cycle();
    end
    if_req_ready = 1'b1;
    cycle();
    stall_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_req_valid !== 1'b0 || if_req_pc !== p0 + 64'd4) begin
      n_err++;
      $display("FAIL stall_drop: valid=%b pc=%h, want 0/%h", if_req_valid, if_req_pc, p0 + 64'd4);
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (if_req_valid !== 1'b1 || if_req_pc !== p0 + 64'd4) begin
      n_err++;
      $display("FAIL stall_resume: valid=%b pc=%h, want 1/%h", if_req_valid, if_req_pc, p0 + 64'd4);
    end
    cycle();
  endtask

  task automatic test_async_reset();
    if_req_ready = 1'b0;
    ex_valid = 1'b1; pc_sel = 2'b10; ex_pc = 64'h1234_5678; ex_imm = 64'h0;
    cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if_req_valid !== 1'b0 || if_req_pc !== 64'h0 || flush_o !== 1'b0 || misalign_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b pc=%h flush=%b mis=%b, want 0/0/0/0", if_req_valid, if_req_pc, flush_o, misalign_o);
    end
    if_req_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_req_valid !== 1'b1 || if_req_pc !== 64'(4 * i)) begin
        n_err++;
        $display("FAIL post_reset[%0d]: valid=%b pc=%h, want 1/%h", i, if_req_valid, if_req_pc, 64'(4 * i));
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ex_valid     = ($urandom_range(0, 3) == 0);
      pc_sel       = 2'($urandom_range(0, 3));
      ex_pc        = {32'($urandom), 32'($urandom)};
      ex_rs1       = {32'($urandom), 32'($urandom)};
      ex_imm       = ($urandom_range(0, 1) == 0) ? 64'($signed(12'($urandom))) : {32'($urandom), 32'($urandom)};
      if_req_ready = ($urandom_range(0, 2) != 0);
      stall_i      = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      n_cmp++;
      if (if_req_valid !== m_req || if_req_pc !== m_pc || flush_o !== m_flush || misalign_o !== m_mis) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b pc=%h flush=%b mis=%b, want %b/%h/%b/%b", i, if_req_valid, if_req_pc, flush_o, misalign_o, m_req, m_pc, m_flush, m_mis);
      end
      cycle();
    end
    idle_inputs();
    stall_i = 1'b0; if_req_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_wrap();
    test_backpressure_redirect();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
